// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the program/data RAM port arbiter: FSM encoding,
// requester IDs and default bus widths.
package mem_port_arbiter_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin chooser: a lone request wins outright,
// a tie goes to the port that did not win last time.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    grant_valid = |req;
    grant_id    = OWN_CPU;
    unique case (req)
      2'b01:   grant_id = OWN_CPU;
      2'b10:   grant_id = OWN_DBG;
      2'b11:   grant_id = ~last;
      default: grant_id = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/vDFF.sv
// Plain N-bit D flip-flop bank. Any reset handling is muxed ahead of D by the user.
module vDFF #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
);

  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) Q <= D;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported program/data RAM between the CPU memory port and the
// debug/loader port; one 3-cycle IDLE/ACCESS/DONE transaction at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy,
  output logic          owner
);

  state_t        w_state;
  state_t        w_state_next;
  logic [1:0]    w_state_d;
  logic [1:0]    w_state_q;

  logic          w_grant_valid;
  logic          w_grant_id;
  logic          w_grant;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  logic          r_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_write;
  logic          r_owner;
  logic          r_last_owner;
  logic          r_cpu_ack;
  logic          r_dbg_ack;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dbg_rdata;

  rr_pick2 u_pick (
    .req         ({dbg_req, cpu_req}),
    .last        (r_last_owner),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  assign w_grant = (w_state == IDLE) && w_grant_valid;

  assign w_sel_we    = (w_grant_id == OWN_DBG) ? dbg_we    : cpu_we;
  assign w_sel_addr  = (w_grant_id == OWN_DBG) ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = (w_grant_id == OWN_DBG) ? dbg_wdata : cpu_wdata;

  always_comb begin
    w_state_next = w_state;
    unique case (w_state)
      IDLE:    if (w_grant_valid) w_state_next = ACCESS;
      ACCESS:  w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_state_d = reset ? w_state_next : IDLE;

  vDFF #(.N(2)) u_state_reg (
    .clk (clk),
    .D   (w_state_d),
    .Q   (w_state_q)
  );

  assign w_state = state_t'(w_state_q);

  // Address/data latch straight into the RAM-facing registers, so they hold
  // their last value outside ACCESS without any extra muxing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we         <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_write  <= 1'b0;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DBG;
      r_cpu_ack    <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_mem_write <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;

      if (w_grant) begin
        r_owner      <= w_grant_id;
        r_last_owner <= w_grant_id;
        r_we         <= w_sel_we;
        r_mem_addr   <= w_sel_addr;
        r_mem_wdata  <= w_sel_wdata;
        r_mem_write  <= w_sel_we;
      end

      if (w_state == ACCESS) begin
        r_cpu_ack <= (r_owner == OWN_CPU);
        r_dbg_ack <= (r_owner == OWN_DBG);
      end

      if ((w_state == DONE) && !r_we) begin
        if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
        else                    r_dbg_rdata <= mem_rdata;
      end
    end
  end

  // A reset arriving during ACCESS must keep the pending write out of the RAM,
  // so the registered enable is also qualified by reset.
  assign mem_write = r_mem_write & reset;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // RAM data only arrives in DONE, so the ack cycle forwards it directly and
  // the holding register takes over from the next cycle on.
  assign cpu_rdata = (r_cpu_ack && !r_we) ? mem_rdata : r_cpu_rdata;
  assign dbg_rdata = (r_dbg_ack && !r_we) ? mem_rdata : r_dbg_rdata;

  assign cpu_ack = r_cpu_ack;
  assign dbg_ack = r_dbg_ack;
  assign busy    = (w_state != IDLE);
  assign owner   = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers queue transactions, a monitor
// scores every ack against a transaction-level memory model.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    int port;
    int cycle;
  } ack_rec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_write;
  logic          busy;
  logic          owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  // Synchronous single-port RAM attached to the DUT.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model and scoreboard state.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] last_rd [2];
  txn_t          exp_cpu[$];
  txn_t          exp_dbg[$];
  ack_rec_t      ack_log[$];
  int            ack_cnt [2];
  int            wr_cycles = 0;
  logic          prev_wr = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score_ack(input int p, input logic [DW-1:0] rd);
    txn_t          t;
    logic [DW-1:0] exp;
    logic          empty;
    ack_cnt[p]++;
    ack_log.push_back('{p, cyc});
    empty = (p == 0) ? (exp_cpu.size() == 0) : (exp_dbg.size() == 0);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL port%0d_unexpected_ack: got ack expected none (cycle %0d)", p, cyc);
      return;
    end
    if (p == 0) t = exp_cpu.pop_front();
    else        t = exp_dbg.pop_front();
    if (t.we) begin
      ref_mem[t.addr] = t.wdata;
      exp = last_rd[p];
    end else begin
      exp = ref_mem[t.addr];
      last_rd[p] = exp;
    end
    check((p == 0) ? "cpu_rdata_at_ack" : "dbg_rdata_at_ack", 64'(rd), 64'(exp));
  endtask

  // Monitor: samples 1 time unit after the falling edge, away from any drive.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      last_rd[0] = '0;
      last_rd[1] = '0;
      prev_wr    = 1'b0;
      exp_cpu.delete();
      exp_dbg.delete();
    end else begin
      check("ack_exclusive", 64'(cpu_ack & dbg_ack), 64'd0);
      check("write_not_back_to_back", 64'(prev_wr & mem_write), 64'd0);
      prev_wr = mem_write;
      if (mem_write) wr_cycles++;
      if (cpu_ack) score_ack(0, cpu_rdata);
      else         check("cpu_rdata_hold", 64'(cpu_rdata), 64'(last_rd[0]));
      if (dbg_ack) score_ack(1, dbg_rdata);
      else         check("dbg_rdata_hold", 64'(dbg_rdata), 64'(last_rd[1]));
    end
  end

  // Driver: raises req, queues the expected transaction, waits (bounded) for
  // this port's ack and drops req in the ack cycle. Called at a falling edge.
  task automatic port_txn(input int p, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int lat,
                          output logic [DW-1:0] rd);
    txn_t t;
    int   t0;
    t  = '{we, addr, wdata};
    rd = '0;
    if (p == 0) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      exp_cpu.push_back(t);
    end else begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      exp_dbg.push_back(t);
    end
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0 && cpu_ack) || (p == 1 && dbg_ack)) begin
        lat = cyc - t0;
        rd  = (p == 0) ? cpu_rdata : dbg_rdata;
        break;
      end
    end
    if (p == 0) cpu_req = 1'b0;
    else        dbg_req = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL port%0d_ack_timeout: got no ack expected ack within 20 cycles", p);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            lat;
    logic [DW-1:0] rd;
    int            base_wr;
    int            base_ack;
    int            k;
    int            exp_port [4];
    int            exp_dly  [4];

    exp_port = '{0, 1, 0, 1};
    exp_dly  = '{2, 5, 8, 11};
    for (int a = 0; a < 256; a++) begin
      ram[a]     = 16'($urandom);
      ref_mem[a] = ram[a];
    end
    ram[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;
    ram[8'h30] = 16'h0000; ref_mem[8'h30] = 16'h0000;
    ack_cnt = '{0, 0};

    // Reset held with both requests pending.
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctrl_outputs", 64'({cpu_ack, dbg_ack, mem_write, busy, owner}), 64'd0);
    check("reset_rdata", 64'({cpu_rdata, dbg_rdata}), 64'd0);
    check("reset_mem_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    reset   = 1'b1;
    @(negedge clk);

    // CPU read alone, with a look at the bus in ACCESS.
    fork
      port_txn(0, 1'b0, 8'h10, 16'h0, lat, rd);
      begin
        @(negedge clk);
        #1;
        check("cpu_read_access_addr", 64'(mem_addr), 64'h10);
        check("cpu_read_access_busy_owner_we", 64'({busy, owner, mem_write}), 64'b100);
        @(negedge clk);
        #1;
        check("cpu_read_no_dbg_ack", 64'(dbg_ack), 64'd0);
      end
    join
    check("cpu_read_latency", 64'(lat), 64'd2);
    check("cpu_read_data", 64'(rd), 64'hBEEF);

    // Debug write alone, then CPU reads it back.
    @(negedge clk);
    base_wr = wr_cycles;
    port_txn(1, 1'b1, 8'h20, 16'h1234, lat, rd);
    check("dbg_write_latency", 64'(lat), 64'd2);
    repeat (2) @(negedge clk);
    check("dbg_write_one_cycle", 64'(wr_cycles - base_wr), 64'd1);
    port_txn(0, 1'b0, 8'h20, 16'h0, lat, rd);
    check("readback_after_dbg_write", 64'(rd), 64'h1234);

    // Fresh reset so the first tie goes to the CPU, then sustained contention.
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ack_log.delete();
    k = cyc;
    fork
      begin
        int l0; logic [DW-1:0] r0;
        port_txn(0, 1'b0, 8'h10, 16'h0, l0, r0);
        port_txn(0, 1'b0, 8'h20, 16'h0, l0, r0);
      end
      begin
        int l1; logic [DW-1:0] r1;
        port_txn(1, 1'b1, 8'h40, 16'h5555, l1, r1);
        port_txn(1, 1'b1, 8'h41, 16'hAAAA, l1, r1);
      end
    join
    #2;
    check("tie_ack_count", 64'(ack_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      check($sformatf("tie_ack%0d_port", i), 64'(ack_log[i].port), 64'(exp_port[i]));
      check($sformatf("tie_ack%0d_cycle", i), 64'(ack_log[i].cycle - k), 64'(exp_dly[i]));
    end

    // Debug request pulsed during a CPU ACCESS is withdrawn.
    @(negedge clk);
    base_ack = ack_cnt[1];
    fork
      port_txn(0, 1'b0, 8'h41, 16'h0, lat, rd);
      begin
        @(negedge clk);
        dbg_req = 1'b1;
        @(negedge clk);
        dbg_req = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    #1;
    check("withdraw_not_granted", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("withdraw_no_dbg_ack", 64'(ack_cnt[1] - base_ack), 64'd0);

    // Reset while a debug write to 0x30 is in ACCESS.
    base_ack = ack_cnt[1];
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h30; dbg_wdata = 16'hABCD;
    @(negedge clk);
    #1;
    check("rst_mid_in_access", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_idle_no_ack", 64'({busy, cpu_ack, dbg_ack, mem_write}), 64'd0);
    reset   = 1'b1;
    dbg_req = 1'b0;
    dbg_we  = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_write_not_committed", 64'(ram[8'h30]), 64'h0000);
    check("rst_mid_no_dbg_ack", 64'(ack_cnt[1] - base_ack), 64'd0);

    // Randomized traffic from both ports over a small shared address window.
    fork
      begin
        int l0; logic [DW-1:0] r0;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          port_txn(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                   16'($urandom), l0, r0);
          check("cpu_latency_bound", 64'(l0 >= 2 && l0 <= 6), 64'd1);
        end
      end
      begin
        int l1; logic [DW-1:0] r1;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          port_txn(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                   16'($urandom), l1, r1);
          check("dbg_latency_bound", 64'(l1 >= 2 && l1 <= 6), 64'd1);
        end
      end
    join
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_cpu.size() + exp_dbg.size()), 64'd0);
    for (int a = 0; a < 16; a++)
      check($sformatf("ram_matches_model_%0h", a), 64'(ram[a]), 64'(ref_mem[a]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single-ported program/data RAM. It shares the RAM between the CPU controller's memory port (instruction fetch, LDR/STR) and a debug/loader port used to preload programs and inspect memory while the CPU runs or is halted. Requests are accepted through a req/ack handshake and granted round-robin. The arbiter drives the RAM address, write data and write enable, and returns read data to the winning requester.

## Interface
- `AW`, 8, RAM address width
- `DW`, 16, RAM data width

- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-low; reset applies when `reset`=0 at a rising edge
- `cpu_req`  in  1  CPU access request
- `cpu_we`  in  1  1=write, 0=read
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_ack`  out  1  one-cycle completion pulse to CPU
- `cpu_rdata`  out  DW  CPU read data; valid when `cpu_ack`=1
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: same as the `cpu_*` signals, for the debug/loader port
- `mem_addr`  out  AW  RAM address
- `mem_wdata`  out  DW  RAM write data
- `mem_write`  out  1  RAM write enable
- `mem_rdata`  in  DW  RAM read data; synchronous RAM, valid the cycle after the address is driven
- `busy`  out  1  high in ACCESS and DONE
- `owner`  out  1  current or last grant owner: 0=CPU, 1=debug

## Operation
- FSM has three states: IDLE, ACCESS, DONE.
- **IDLE**
  - Samples `cpu_req` and `dbg_req` at each edge.
  - One request pending: grant that requester.
  - Both pending: grant the port that did not win the previous grant.
  - On grant: latch the winner's `we`, `addr` and `wdata` into internal registers, set `owner`, go to ACCESS.
  - No request: stay in IDLE.
- **ACCESS** (exactly 1 cycle)
  - `mem_addr` and `mem_wdata` come from the latched values.
  - `mem_write` = latched `we`.
  - Next state: DONE.
- **DONE** (exactly 1 cycle)
  - `mem_write`=0.
  - Assert `ack` for `owner` only.
  - Owner's `rdata` = `mem_rdata`, registered and held until that port's next ack.
  - For writes, `rdata` keeps its previous value.
  - Next state: IDLE.
- Requester rules:
  - A requester keeps `req` high until it sees `ack`.
  - It may then drop `req`, or keep it high to request again.
  - A `req` still high in the IDLE cycle after DONE is a new request.
  - `req` dropped before grant: the request is silently withdrawn.
  - `we`, `addr` and `wdata` are only required stable at the grant edge.
- Round-robin memory:
  - A `last_owner` flop updates on every grant.
  - Reset value is 1 (debug), so the CPU wins the first tie.
- Outputs when not in ACCESS: `mem_addr` and `mem_wdata` hold their last values; `mem_write`=0.
- Reset values: state=IDLE, `cpu_ack`=`dbg_ack`=0, `cpu_rdata`=`dbg_rdata`=0, `mem_addr`=0, `mem_wdata`=0, `mem_write`=0, `busy`=0, `owner`=0, `last_owner`=1.
- Reset mid-operation:
  - Abandons the access and returns to IDLE next cycle.
  - No ack is issued for the abandoned access.
  - A write in ACCESS at the reset edge does not commit, because `mem_write` is 0 in the following cycle.

## Timing
- Request sampled high in IDLE at edge k: ACCESS in cycle k+1, `ack` high in cycle k+2, IDLE at k+3.
- Latency from req to ack is 2 cycles; one access completes every 3 cycles minimum.
- Under continuous contention, CPU and debug alternate, so each gets one access per 6 cycles.
- No starvation: worst-case wait is 3 cycles plus the port's own 3-cycle access.
- `mem_write` is never high in two consecutive cycles.
- `ack` is never high for both ports in the same cycle.

## Structure
- Shared package or header holds:
  - State encodings: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10.
  - Owner IDs: OWN_CPU=1'b0, OWN_DBG=1'b1.
  - Default `AW` and `DW`.
- State register uses the existing `vDFF` module; reset muxing (`reset`=0 forces IDLE) sits ahead of it.
- The one natural sub-module is `rr_pick2`: combinational 2-way round-robin chooser.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `grant_valid`, `grant_id`.
- Datapath latches and registered rdata stay inline; expected size is about 150–200 lines.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with both reqs high -> all outputs 0, `last_owner`=1, no ack.
- CPU read alone: RAM[0x10]=0xBEEF, `cpu_req`=1 with `addr`=0x10 at edge k -> `mem_addr`=0x10 in k+1, `cpu_ack`=1 and `cpu_rdata`=0xBEEF in k+2, `dbg_ack` stays 0.
- Debug write alone: `dbg_we`=1, `addr`=0x20, `wdata`=0x1234 -> `mem_write`=1 for exactly one cycle; a later CPU read of 0x20 returns 0x1234.
- Tie after reset: both reqs high and held -> grant order CPU, DBG, CPU, DBG; acks at cycles k+2, k+5, k+8, k+11.
- Withdrawal: `dbg_req` pulsed for 1 cycle while the CPU access is in ACCESS -> no debug grant, no `dbg_ack`.
- Reset during ACCESS of a write to 0x30 (old value 0x0000) -> FSM in IDLE next cycle, no ack, RAM[0x30] still 0x0000.
